// File: rtl/alu_uart_sequencer.sv
// rtl/alu_uart_sequencer.sv - UART-to-ALU front end: collects A, B, opcode bytes and returns the ALU result.
// Drops bytes while busy. Rejects illegal opcodes. Counts completed operations.
module alu_uart_sequencer #(
  parameter int SIZEDATA = 8,
  parameter int SIZEOP   = 6
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [SIZEDATA-1:0] RX_DATA,
  input  logic                RX_DONE,
  output logic [SIZEDATA-1:0] DATOA,
  output logic [SIZEDATA-1:0] DATOB,
  output logic [SIZEOP-1:0]   OPCODE,
  input  logic [SIZEDATA-1:0] RESULT,
  output logic [SIZEDATA-1:0] TX_DATA,
  output logic                TX_START,
  input  logic                TX_DONE,
  output logic                BUSY,
  output logic                OP_ERROR,
  output logic [7:0]          OP_COUNT
);

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_B    = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_SEND = 3'd4;
  localparam logic [2:0] S_WAIT = 3'd5;

  logic [2:0]          r_state;
  logic [SIZEDATA-1:0] r_datoa;
  logic [SIZEDATA-1:0] r_datob;
  logic [SIZEOP-1:0]   r_opcode;
  logic [SIZEDATA-1:0] r_tx_data;
  logic                r_op_error;
  logic [7:0]          r_op_count;

  logic [SIZEDATA-1:0] w_high;
  logic [SIZEOP-1:0]   w_low;
  logic                w_op_legal;

  // Shift rather than slice so SIZEOP == SIZEDATA stays legal.
  assign w_high = RX_DATA >> SIZEOP;
  assign w_low  = RX_DATA[SIZEOP-1:0];

  always_comb begin
    w_op_legal = 1'b0;
    if (w_high == '0) begin
      case (w_low)
        SIZEOP'(8'h20), SIZEOP'(8'h22), SIZEOP'(8'h24), SIZEOP'(8'h25),
        SIZEOP'(8'h26), SIZEOP'(8'h27), SIZEOP'(8'h02), SIZEOP'(8'h03):
          w_op_legal = 1'b1;
        default: w_op_legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state    <= S_A;
      r_datoa    <= '0;
      r_datob    <= '0;
      r_opcode   <= '0;
      r_tx_data  <= '0;
      r_op_error <= 1'b0;
      r_op_count <= 8'd0;
    end else begin
      r_op_error <= 1'b0;
      case (r_state)
        S_A: if (RX_DONE) begin
          r_datoa <= RX_DATA;
          r_state <= S_B;
        end
        S_B: if (RX_DONE) begin
          r_datob <= RX_DATA;
          r_state <= S_OP;
        end
        S_OP: if (RX_DONE) begin
          if (w_op_legal) begin
            r_opcode <= w_low;
            r_state  <= S_EXEC;
          end else begin
            r_op_error <= 1'b1;
            r_state    <= S_A;
          end
        end
        S_EXEC: begin
          r_tx_data <= RESULT;
          r_state   <= S_SEND;
        end
        S_SEND: r_state <= S_WAIT;
        S_WAIT: if (TX_DONE) begin
          r_op_count <= r_op_count + 8'd1;
          r_state    <= S_A;
        end
        default: r_state <= S_A;
      endcase
    end
  end

  assign DATOA    = r_datoa;
  assign DATOB    = r_datob;
  assign OPCODE   = r_opcode;
  assign TX_DATA  = r_tx_data;
  assign OP_ERROR = r_op_error;
  assign OP_COUNT = r_op_count;
  assign TX_START = (r_state == S_SEND);
  assign BUSY     = (r_state == S_EXEC) || (r_state == S_SEND) || (r_state == S_WAIT);

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// tb/tb_alu_uart_sequencer.sv - directed bench with a scoreboard of expected transmit bytes.
module tb_alu_uart_sequencer;

  logic       CLK = 1'b0;
  logic       RESET_N, RX_DONE, TX_DONE;
  logic [7:0] RX_DATA, RESULT, DATOA, DATOB, TX_DATA, OP_COUNT;
  logic [5:0] OPCODE;
  logic       TX_START, BUSY, OP_ERROR;

  int         n_vec = 0;
  int         n_err = 0;
  int         tx_start_seen = 0;
  logic [7:0] exp_count = 8'd0;
  logic [7:0] sb_q[$];
  logic [7:0] ops[8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};

  always #5 CLK = ~CLK;

  alu_uart_sequencer #(.SIZEDATA(8), .SIZEOP(6)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .RX_DATA(RX_DATA), .RX_DONE(RX_DONE),
    .DATOA(DATOA), .DATOB(DATOB), .OPCODE(OPCODE), .RESULT(RESULT),
    .TX_DATA(TX_DATA), .TX_START(TX_START), .TX_DONE(TX_DONE),
    .BUSY(BUSY), .OP_ERROR(OP_ERROR), .OP_COUNT(OP_COUNT)
  );

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   alu = a + b;
      6'h22:   alu = a - b;
      6'h24:   alu = a & b;
      6'h25:   alu = a | b;
      6'h26:   alu = a ^ b;
      6'h27:   alu = ~(a | b);
      6'h02:   alu = a >> b;
      6'h03:   alu = $signed(a) >>> b;
      default: alu = 8'h00;
    endcase
  endfunction

  assign RESULT = alu(DATOA, DATOB, OPCODE);

  always @(negedge CLK) if (TX_START === 1'b1) tx_start_seen++;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_DATA = b;
    RX_DONE = 1'b1;
    tick;
    RX_DONE = 1'b0;
  endtask

  task automatic tx_done_pulse;
    TX_DONE = 1'b1;
    tick;
    TX_DONE = 1'b0;
  endtask

  task automatic finish_op(input logic [7:0] op, input logic [7:0] exp, input int hold,
                           input bit inject, input bit early_done, input logic [7:0] a_keep);
    int w;
    int s0;
    sb_q.push_back(exp);
    s0 = tx_start_seen;
    send_byte(op);
    check("opcode", OPCODE, op);
    check("busy_exec", BUSY, 1);
    w = 0;
    while (TX_START !== 1'b1 && w < 8) begin
      tick;
      w++;
    end
    if (w >= 8) begin
      check("tx_start_timeout", 0, 1);
      void'(sb_q.pop_front());
    end else begin
      check("tx_start_latency", w, 1);
      check("tx_data", TX_DATA, sb_q.pop_front());
    end
    if (early_done) TX_DONE = 1'b1;
    tick;
    TX_DONE = 1'b0;
    check("tx_start_one_cycle", TX_START, 0);
    check("busy_wait", BUSY, 1);
    for (int i = 0; i < hold; i++) begin
      if (inject && (i % 10 == 0)) begin
        RX_DATA = 8'hAA;
        RX_DONE = 1'b1;
      end
      tick;
      RX_DONE = 1'b0;
      if (inject) begin
        check("busy_hold", BUSY, 1);
        check("datoa_hold", DATOA, a_keep);
      end
    end
    tx_done_pulse;
    exp_count = exp_count + 8'd1;
    check("op_count", OP_COUNT, exp_count);
    check("busy_idle", BUSY, 0);
    check("tx_start_pulses", tx_start_seen, s0 + 1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input logic [7:0] exp);
    send_byte(a);
    send_byte(b);
    check("datoa", DATOA, a);
    check("datob", DATOB, b);
    finish_op(op, exp, 0, 1'b0, 1'b0, a);
  endtask

  task automatic do_reset;
    RESET_N = 1'b0;
    tick;
    RESET_N = 1'b1;
    exp_count = 8'd0;
  endtask

  initial begin
    int s0;
    logic [7:0] a, b, op;
    RESET_N = 1'b0; RX_DONE = 1'b0; TX_DONE = 1'b0; RX_DATA = 8'h00;
    tick;
    do_reset;
    check("rst_datoa", DATOA, 0);
    check("rst_datob", DATOB, 0);
    check("rst_opcode", OPCODE, 0);
    check("rst_tx_data", TX_DATA, 0);
    check("rst_op_count", OP_COUNT, 0);
    check("rst_flags", {TX_START, OP_ERROR, BUSY}, 0);

    run_op(8'h05, 8'h03, 8'h20, 8'h08);
    run_op(8'h03, 8'h05, 8'h22, 8'hFE);
    run_op(8'h80, 8'h03, 8'h03, 8'hF0);
    run_op(8'h80, 8'h03, 8'h02, 8'h10);

    // Illegal opcodes: error pulse only, no transmit, back to operand A.
    s0 = tx_start_seen;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h21);
    check("err_pulse_21", OP_ERROR, 1);
    check("err_busy_21", BUSY, 0);
    check("err_opcode_kept_21", OPCODE, 6'h02);
    tick;
    check("err_one_cycle_21", OP_ERROR, 0);
    send_byte(8'h07); send_byte(8'h08); send_byte(8'h60);
    check("err_pulse_60", OP_ERROR, 1);
    check("err_datoa_kept_60", DATOA, 8'h07);
    check("err_datob_kept_60", DATOB, 8'h08);
    tick;
    check("err_one_cycle_60", OP_ERROR, 0);
    check("err_no_tx_start", tx_start_seen, s0);
    run_op(8'h0F, 8'hF0, 8'h25, 8'hFF);

    // Bytes arriving while waiting for the transmitter are dropped.
    send_byte(8'h12); send_byte(8'h34);
    finish_op(8'h26, 8'h26, 50, 1'b1, 1'b0, 8'h12);
    send_byte(8'h11);
    check("datoa_after_busy", DATOA, 8'h11);
    send_byte(8'h44);
    finish_op(8'h24, 8'h00, 2, 1'b0, 1'b1, 8'h11);

    // Reset while waiting aborts the operation.
    send_byte(8'h09); send_byte(8'h01);
    sb_q.push_back(8'h0A);
    send_byte(8'h20);
    tick;
    check("pre_reset_tx_start", TX_START, 1);
    check("pre_reset_tx_data", TX_DATA, sb_q.pop_front());
    tick;
    s0 = tx_start_seen;
    do_reset;
    check("abort_outputs", {DATOA, DATOB, OPCODE, TX_DATA, OP_COUNT}, 0);
    check("abort_flags", {TX_START, OP_ERROR, BUSY}, 0);
    tx_done_pulse;
    tick;
    check("abort_late_done_count", OP_COUNT, 0);
    check("abort_no_tx_start", tx_start_seen, s0);
    send_byte(8'h33);
    check("abort_next_datoa", DATOA, 8'h33);
    send_byte(8'h01);
    finish_op(8'h20, 8'h34, 0, 1'b0, 1'b0, 8'h33);

    // Stray TX_DONE while idle is ignored.
    s0 = tx_start_seen;
    tx_done_pulse;
    check("stray_done_count", OP_COUNT, exp_count);
    check("stray_done_busy", BUSY, 0);
    check("stray_done_no_start", tx_start_seen, s0);

    // Counter wrap.
    do_reset;
    for (int i = 0; i < 256; i++) begin
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 7));
      op = ops[$urandom_range(0, 7)];
      run_op(a, b, op, alu(a, b, op[5:0]));
      if (i == 254) check("op_count_ff", OP_COUNT, 8'hFF);
    end
    check("op_count_wrap", OP_COUNT, 8'h00);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_uart_sequencer.md
Name: alu_uart_sequencer

Overview:
- Front-end controller for the ALU: collects three bytes from the UART receiver (DATOA, DATOB, OPCODE, in that order) and drives them onto the ALU ports.
- After the ALU settles, captures RESULT and hands it to the UART transmitter with a start/done handshake.
- Sits between uart_rx/uart_tx and the combinational ALU in the board top.
- Rejects illegal opcodes and counts completed operations.

Parameters:
- SIZEDATA, 8, operand/result/UART byte width
- SIZEOP, 6, ALU opcode width (must be <= SIZEDATA)

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RESET_N  in  1  synchronous, active-low reset
- RX_DATA  in  SIZEDATA  received byte, valid when RX_DONE=1
- RX_DONE  in  1  one-cycle pulse per received byte
- DATOA  out  SIZEDATA  ALU operand A (registered)
- DATOB  out  SIZEDATA  ALU operand B (registered)
- OPCODE  out  SIZEOP  ALU opcode (registered)
- RESULT  in  SIZEDATA  ALU combinational result
- TX_DATA  out  SIZEDATA  byte to transmit (registered)
- TX_START  out  1  one-cycle pulse requesting transmission
- TX_DONE  in  1  one-cycle pulse, transmitter finished
- BUSY  out  1  high while executing/transmitting (bytes dropped)
- OP_ERROR  out  1  one-cycle pulse on illegal opcode byte
- OP_COUNT  out  8  completed-operation counter, wraps

Behaviour:
- Clock and reset: one clock (CLK); reset is synchronous and active-low (RESET_N).
- Reset (RESET_N=0 at a rising edge):
  - state=S_A.
  - DATOA, DATOB, OPCODE, TX_DATA, OP_COUNT = 0.
  - TX_START, OP_ERROR, BUSY = 0.
  - Reset in any state aborts the operation. TX_START is never issued for an aborted operation.
- State machine (Moore outputs except where noted):
  - S_A: on RX_DONE, DATOA<=RX_DATA, go to S_B.
  - S_B: on RX_DONE, DATOB<=RX_DATA, go to S_OP.
  - S_OP: on RX_DONE, the byte is legal iff RX_DATA[SIZEDATA-1:SIZEOP]==0 and RX_DATA[SIZEOP-1:0] is one of: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x02 SRL, 0x03 SRA.
    - Legal: OPCODE<=RX_DATA[SIZEOP-1:0], go to S_EXEC.
    - Illegal: OP_ERROR=1 next cycle (registered, one cycle), go to S_A. OPCODE, DATOA and DATOB keep their old values.
  - S_EXEC: one settle cycle. TX_DATA<=RESULT at end of cycle, go to S_SEND.
  - S_SEND: TX_START=1 for exactly this cycle, go to S_WAIT.
  - S_WAIT: hold until TX_DONE, then OP_COUNT<=OP_COUNT+1 (255 wraps to 0) and go to S_A.
- BUSY=1 in S_EXEC, S_SEND, S_WAIT; 0 otherwise.
- RX_DONE while BUSY=1: byte discarded, no state or register change.
- TX_DONE outside S_WAIT: ignored.
- TX_DONE in S_SEND: ignored. Completion is only accepted from S_WAIT.
- Latency:
  - Opcode RX_DONE at cycle n: OPCODE valid from n+1 (S_EXEC).
  - TX_DATA valid from n+2; TX_START high in cycle n+2.
  - Earliest next accepted byte is the cycle after TX_DONE.
- Operand outputs stay stable from capture until overwritten by the next valid byte for that slot, so the ALU inputs never glitch during S_EXEC/S_SEND/S_WAIT.
- TX_DATA holds its value until the next S_EXEC.
- No arithmetic in this block apart from the 8-bit wrapping OP_COUNT increment.
- No data is buffered beyond one operand triple.

Test Plan:
- Bytes 0x05, 0x03, 0x20 (reference ALU model attached) -> DATOA=0x05, DATOB=0x03, OPCODE=0x20; TX_DATA=0x08 with a single TX_START pulse two cycles after the third RX_DONE; after TX_DONE, OP_COUNT=1, BUSY=0.
- Bytes 0x03, 0x05, 0x22 -> TX_DATA=0xFE. Bytes 0x80, 0x03, 0x03 -> TX_DATA=0xF0. Bytes 0x80, 0x03, 0x02 -> TX_DATA=0x10.
- Opcode byte 0x21, then 0x60 -> OP_ERROR pulses exactly one cycle each, no TX_START, state back to S_A; following triple 0x0F, 0xF0, 0x25 -> TX_DATA=0xFF.
- RX_DONE pulses with 0xAA while in S_WAIT (TX_DONE held off 50 cycles) -> DATOA unchanged, BUSY=1 throughout; after TX_DONE, the next byte loads DATOA.
- RESET_N=0 for one cycle while in S_WAIT -> all outputs 0, late TX_DONE ignored, OP_COUNT stays 0, next byte loads DATOA.
- 256 back-to-back legal operations -> OP_COUNT wraps to 0x00; TX_DONE injected without a prior TX_START has no effect.
